bus_arbiter: RTL and testbench



---
 rtl/bus_arbiter.sv | 142 ++++++++++++++
 tb/tb_bus_arbiter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Four-master bus arbiter with registered active-low grants and tenure-limited preemption.
// Define BUS_ARB_ROUND_ROBIN_EN for round-robin priority; otherwise master 0 > 1 > 2 > 3.
module bus_arbiter #(
   parameter int MAX_TENURE = 16,
   parameter int CNT_WIDTH  = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req0_,
   input  logic       req1_,
   input  logic       req2_,
   input  logic       req3_,
   output logic       grnt0_,
   output logic       grnt1_,
   output logic       grnt2_,
   output logic       grnt3_,
   output logic [1:0] owner,
   output logic       busy
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BUSY,
      ST_REVOKE
   } state_t;

   localparam bit                   PREEMPT_EN  = (MAX_TENURE != 0);
   localparam logic [CNT_WIDTH-1:0] TENURE_SAT  = '1;
   localparam logic [CNT_WIDTH-1:0] TENURE_LAST =
      CNT_WIDTH'((MAX_TENURE == 0) ? 0 : MAX_TENURE - 1);

   state_t               r_state;
   logic [3:0]           r_gnt_n;
   logic                 r_busy;
   logic [1:0]           r_owner;
   logic [1:0]           r_last_owner;
   logic [CNT_WIDTH-1:0] r_tenure;

   logic [3:0] w_req;
   logic [3:0] w_owner_oh;
   logic       w_owner_req;
   logic       w_others;
   logic [3:0] w_cand;
   logic [1:0] w_start;
   logic [1:0] w_idx;
   logic       w_win_vld;
   logic [1:0] w_win;
   logic       w_preempt;

   assign w_req = ~{req3_, req2_, req1_, req0_};

   always_comb begin
      w_owner_oh  = 4'b0001 << r_owner;
      w_owner_req = |(w_req & w_owner_oh);
      w_others    = |(w_req & ~w_owner_oh);
      // r_owner still names the preempted master while in REVOKE
      w_cand      = (r_state == ST_REVOKE) ? (w_req & ~w_owner_oh) : w_req;
`ifdef BUS_ARB_ROUND_ROBIN_EN
      w_start     = r_last_owner + 2'd1;
`else
      w_start     = 2'd0;
`endif
      w_idx       = '0;
      w_win_vld   = 1'b0;
      w_win       = '0;
      for (int unsigned i = 0; i < 4; i++) begin
         w_idx = w_start + 2'(i);
         if (!w_win_vld && w_cand[w_idx]) begin
            w_win_vld = 1'b1;
            w_win     = w_idx;
         end
      end
      w_preempt = PREEMPT_EN && (r_state == ST_BUSY) && w_owner_req &&
                  (r_tenure == TENURE_LAST) && w_others;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_gnt_n      <= '1;
         r_busy       <= 1'b0;
         r_owner      <= '0;
         r_last_owner <= 2'd3;
         r_tenure     <= '0;
      end else begin
         case (r_state)
            ST_BUSY: begin
               if (w_preempt) begin
                  r_state <= ST_REVOKE;
                  r_gnt_n <= '1;
                  r_busy  <= 1'b0;
               end else if (w_owner_req) begin
                  if (r_tenure != TENURE_SAT)
                     r_tenure <= r_tenure + CNT_WIDTH'(1);
               end else if (w_win_vld) begin
                  r_state      <= ST_BUSY;
                  r_gnt_n      <= ~(4'b0001 << w_win);
                  r_busy       <= 1'b1;
                  r_owner      <= w_win;
                  r_last_owner <= w_win;
                  r_tenure     <= '0;
               end else begin
                  r_state <= ST_IDLE;
                  r_gnt_n <= '1;
                  r_busy  <= 1'b0;
               end
            end
            ST_IDLE, ST_REVOKE: begin
               if (w_win_vld) begin
                  r_state      <= ST_BUSY;
                  r_gnt_n      <= ~(4'b0001 << w_win);
                  r_busy       <= 1'b1;
                  r_owner      <= w_win;
                  r_last_owner <= w_win;
                  r_tenure     <= '0;
               end else begin
                  r_state <= ST_IDLE;
                  r_gnt_n <= '1;
                  r_busy  <= 1'b0;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_gnt_n <= '1;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign {grnt3_, grnt2_, grnt1_, grnt0_} = r_gnt_n;
   assign owner = r_owner;
   assign busy  = r_busy;

   a_onehot_grant: assert property (@(posedge clk) disable iff (reset)
      $onehot0(~r_gnt_n));
   a_busy_match: assert property (@(posedge clk) disable iff (reset)
      r_busy == !(&r_gnt_n));
   a_last_owner: assert property (@(posedge clk) disable iff (reset)
      (r_state == ST_BUSY) |-> (r_last_owner == r_owner));

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter (MAX_TENURE = 4); expectations follow
// BUS_ARB_ROUND_ROBIN_EN when that macro is defined for the build.
module tb_bus_arbiter;

   logic       clk = 1'b0;
   logic       reset;
   logic       req0_, req1_, req2_, req3_;
   logic       grnt0_, grnt1_, grnt2_, grnt3_;
   logic [1:0] owner;
   logic       busy;
   logic [3:0] w_gnt;

   int n_checks = 0;
   int n_pass   = 0;

`ifdef BUS_ARB_ROUND_ROBIN_EN
   localparam logic [3:0] HO_FIRST   = 4'b1011;
   localparam int         HO_FIRST_O = 2;
   localparam logic [3:0] HO_REL     = 4'b1110;
   localparam logic [3:0] HO_SECOND  = 4'b1110;
   localparam int         AF_MOD     = 4;
`else
   localparam logic [3:0] HO_FIRST   = 4'b1110;
   localparam int         HO_FIRST_O = 0;
   localparam logic [3:0] HO_REL     = 4'b1011;
   localparam logic [3:0] HO_SECOND  = 4'b1011;
   localparam int         AF_MOD     = 2;
`endif

   always #5 clk = ~clk;

   assign w_gnt = {grnt3_, grnt2_, grnt1_, grnt0_};

   bus_arbiter #(
      .MAX_TENURE (4),
      .CNT_WIDTH  (8)
   ) u_dut (
      .clk    (clk),
      .reset  (reset),
      .req0_  (req0_),
      .req1_  (req1_),
      .req2_  (req2_),
      .req3_  (req3_),
      .grnt0_ (grnt0_),
      .grnt1_ (grnt1_),
      .grnt2_ (grnt2_),
      .grnt3_ (grnt3_),
      .owner  (owner),
      .busy   (busy)
   );

   task automatic chk(input string tag, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input logic [3:0] r_n);
      {req3_, req2_, req1_, req0_} = r_n;
   endtask

   task automatic reset_pulse();
      reset = 1'b1;
      set_req(4'b1111);
      tick();
      tick();
      reset = 1'b0;
   endtask

   logic [3:0] exp03 [11];
   logic [3:0] exp_g;
   int         m;

   initial begin
      exp03 = '{4'b1110, 4'b1110, 4'b1110, 4'b1110, 4'b1111,
                4'b0111, 4'b0111, 4'b0111, 4'b0111, 4'b1111, 4'b1110};

      // reset held with everyone requesting
      reset = 1'b1;
      set_req(4'b0000);
      tick();
      tick();
      chk("rst_gnt",   w_gnt, 4'b1111);
      chk("rst_busy",  busy,  0);
      chk("rst_owner", owner, 0);
      reset = 1'b0;
      tick();
      chk("first_gnt",   w_gnt, 4'b1110);
      chk("first_owner", owner, 0);
      chk("first_busy",  busy,  1);
      set_req(4'b1111);
      tick();
      chk("rel_gnt",  w_gnt, 4'b1111);
      chk("rel_busy", busy,  0);

      // single request from master 1
      set_req(4'b1101);
      tick();
      chk("m1_gnt",   w_gnt, 4'b1101);
      chk("m1_owner", owner, 1);
      chk("m1_busy",  busy,  1);
      tick();
      chk("m1_hold",  w_gnt, 4'b1101);
      set_req(4'b1111);
      tick();
      chk("m1_rel_gnt",  w_gnt, 4'b1111);
      chk("m1_rel_busy", busy,  0);

      // handover between masters 0 and 2 with no gap
      set_req(4'b1010);
      tick();
      chk("ho_first",   w_gnt, HO_FIRST);
      chk("ho_first_o", owner, HO_FIRST_O);
      set_req(HO_REL);
      tick();
      chk("ho_second",  w_gnt, HO_SECOND);
      chk("ho_busy",    busy,  1);
      set_req(4'b1111);
      tick();
      chk("ho_idle",    w_gnt, 4'b1111);

      // masters 0 and 3 contending: preemption and REVOKE exclusion
      reset_pulse();
      set_req(4'b0110);
      for (int e = 0; e < 11; e++) begin
         tick();
         chk($sformatf("p03_e%0d", e + 1), w_gnt, exp03[e]);
         chk($sformatf("p03_busy_e%0d", e + 1), busy, (exp03[e] == 4'b1111) ? 0 : 1);
      end

      // REVOKE with only the preempted master left falls to IDLE
      reset_pulse();
      set_req(4'b1100);
      for (int e = 0; e < 4; e++) begin
         tick();
         chk($sformatf("rv_hold_e%0d", e + 1), w_gnt, 4'b1110);
      end
      tick();
      chk("rv_gap", w_gnt, 4'b1111);
      set_req(4'b1110);
      tick();
      chk("rv_idle",      w_gnt, 4'b1111);
      chk("rv_idle_busy", busy,  0);
      tick();
      chk("rv_regrant",   w_gnt, 4'b1110);

      // all four requesting
      reset_pulse();
      set_req(4'b0000);
      for (int e = 0; e < 21; e++) begin
         tick();
         m = (e / 5) % AF_MOD;
         exp_g = ((e % 5) == 4) ? 4'b1111 : ~(4'b0001 << m);
         chk($sformatf("all_e%0d", e + 1), w_gnt, exp_g);
         if ((e % 5) != 4) chk($sformatf("all_owner_e%0d", e + 1), owner, m);
      end

      // reset during master 2's tenure
      reset_pulse();
      set_req(4'b1011);
      tick();
      chk("mid_owner", owner, 2);
      tick();
      tick();
      chk("mid_hold", w_gnt, 4'b1011);
      reset = 1'b1;
      set_req(4'b0000);
      tick();
      chk("mid_rst_gnt",   w_gnt, 4'b1111);
      chk("mid_rst_busy",  busy,  0);
      chk("mid_rst_owner", owner, 0);
      reset = 1'b0;
      tick();
      chk("mid_after_gnt",   w_gnt, 4'b1110);
      chk("mid_after_owner", owner, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
